xcorr_pair_feeder: RTL and testbench

- Buffers one frame of DEPTH samples per microphone channel (NCH channels).
- Then streams each selected channel pair, zero-padded, into the cross-correlator through its series_x/series_y/start interface.
- Collects the correlator's complete/result outputs and tags each result with its pair index and lag count.
- Sits in the mic subsystem between the sign-extension stage and the correlator. It replaces the hard-wired single-pair feed with a parametrised multi-pair sequencer.

---
 rtl/xcorr_feed_pkg.sv | 18 +
 rtl/feed_frame_ram.sv | 30 +++
 rtl/xcorr_pair_feeder.sv | 245 ++++++++++++++++++++++++
 tb/tb_xcorr_pair_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_feed_pkg.sv
// Shared state encoding and width helper for the correlator pair feeder.
package xcorr_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARM,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feed_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/feed_frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
module feed_frame_ram
    import xcorr_feed_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int AW    = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and one-cycle registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/xcorr_pair_feeder.sv
// Buffers one multi-channel frame, then streams each channel pair (zero padded)
// into the cross-correlator and tags the returned results with pair and lag.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for run; correlator held in start
// ST_FILL   | accepting DEPTH frame words into the RAM
// ST_ARM    | xc_start high ARM_CYC cycles, lag counter cleared
// ST_STREAM | k = 0..DEPTH+PAD: zero, DEPTH samples, then PAD zeros
// ST_DRAIN  | waiting until NLAG results of this pair have arrived
// ST_DONE   | one-cycle done pulse
module xcorr_pair_feeder
    import xcorr_feed_pkg::*;
#(
    parameter int W       = 16,
    parameter int DEPTH   = 512,
    parameter int NCH     = 4,
    parameter int PAD     = 512,
    parameter int NLAG    = 1023,
    parameter int RW      = 32,
    parameter int ARM_CYC = 2,
    localparam int AW     = width_of(DEPTH),
    localparam int PW     = width_of(NCH),
    localparam int LW     = width_of(NLAG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                abort,
    input  logic                pair_mode,
    input  logic                in_valid,
    input  logic [NCH*W-1:0]    in_data,
    output logic                in_ready,
    output logic signed [W-1:0] series_x,
    output logic signed [W-1:0] series_y,
    output logic                xc_start,
    input  logic                xc_complete,
    input  logic [RW-1:0]       xc_result,
    output logic                res_valid,
    output logic [RW-1:0]       res_data,
    output logic [PW-1:0]       res_pair,
    output logic [LW-1:0]       res_lag,
    output logic                busy,
    output logic                done
);

    localparam int KW = width_of(DEPTH + PAD + 1);
    localparam int CW = width_of(ARM_CYC);

    localparam logic [AW-1:0] WADDR_LAST = AW'(DEPTH - 1);
    localparam logic [KW-1:0] K_DEPTH    = KW'(DEPTH);
    localparam logic [KW-1:0] K_LAST     = KW'(DEPTH + PAD);
    localparam logic [CW-1:0] ARM_LAST   = CW'(ARM_CYC - 1);
    localparam logic [LW-1:0] LAG_MAX    = LW'(NLAG);
    localparam logic [PW-1:0] PAIR_LAST  = PW'(NCH - 2);

    feed_state_e state_q, state_d;
    logic                mode_q, mode_d;
    logic [PW-1:0]       pair_q, pair_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [CW-1:0]       arm_cnt_q, arm_cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [LW-1:0]       lag_q, lag_d;
    logic signed [W-1:0] series_x_q, series_x_d;
    logic signed [W-1:0] series_y_q, series_y_d;
    logic                res_valid_q, res_valid_d;
    logic [RW-1:0]       res_data_q, res_data_d;
    logic [PW-1:0]       res_pair_q, res_pair_d;
    logic [LW-1:0]       res_lag_q, res_lag_d;

    logic                ram_we;
    logic [AW-1:0]       ram_raddr;
    logic [NCH*W-1:0]    ram_rdata;
    logic [PW-1:0]       x_ch, y_ch;
    logic                pair_active;

    feed_frame_ram #(
        .WIDTH (NCH * W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr_q),
        .wdata (in_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // RAM control and channel select. The read address runs one ahead of k so
    // that, after the RAM and series registers, cycle k shows sample k-1.
    always_comb begin
        ram_we      = (state_q == ST_FILL) && in_valid;
        ram_raddr   = '0;
        if (state_q == ST_STREAM) begin
            ram_raddr = AW'(k_q + 1'b1);
        end
        x_ch        = mode_q ? pair_q : '0;
        y_ch        = pair_q + 1'b1;
        pair_active = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    end

    // Next-state, counters, series and result forwarding; abort overrides all.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pair_d      = pair_q;
        waddr_d     = waddr_q;
        arm_cnt_d   = arm_cnt_q;
        k_d         = k_q;
        lag_d       = lag_q;
        series_x_d  = '0;
        series_y_d  = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_pair_d  = res_pair_q;
        res_lag_d   = res_lag_q;

        if (pair_active && xc_complete && (lag_q != LAG_MAX)) begin
            res_valid_d = 1'b1;
            res_data_d  = xc_result;
            res_pair_d  = pair_q;
            res_lag_d   = lag_q;
            lag_d       = lag_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    mode_d  = pair_mode;
                    pair_d  = '0;
                    waddr_d = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    if (waddr_q == WADDR_LAST) begin
                        waddr_d   = '0;
                        arm_cnt_d = '0;
                        state_d   = ST_ARM;
                    end else begin
                        waddr_d = waddr_q + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                lag_d = '0;
                k_d   = '0;
                if (arm_cnt_q == ARM_LAST) begin
                    arm_cnt_d = '0;
                    state_d   = ST_STREAM;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (k_q < K_DEPTH) begin
                    series_x_d = ram_rdata[int'(x_ch)*W +: W];
                    series_y_d = ram_rdata[int'(y_ch)*W +: W];
                end
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (lag_q == LAG_MAX) begin
                    if (pair_q < PAIR_LAST) begin
                        pair_d    = pair_q + 1'b1;
                        arm_cnt_d = '0;
                        state_d   = ST_ARM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            pair_d      = '0;
            waddr_d     = '0;
            arm_cnt_d   = '0;
            k_d         = '0;
            lag_d       = '0;
            series_x_d  = '0;
            series_y_d  = '0;
            res_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            pair_q      <= '0;
            waddr_q     <= '0;
            arm_cnt_q   <= '0;
            k_q         <= '0;
            lag_q       <= '0;
            series_x_q  <= '0;
            series_y_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_pair_q  <= '0;
            res_lag_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pair_q      <= pair_d;
            waddr_q     <= waddr_d;
            arm_cnt_q   <= arm_cnt_d;
            k_q         <= k_d;
            lag_q       <= lag_d;
            series_x_q  <= series_x_d;
            series_y_q  <= series_y_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_pair_q  <= res_pair_d;
            res_lag_q   <= res_lag_d;
        end
    end

    assign in_ready  = (state_q == ST_FILL);
    assign xc_start  = !pair_active;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign series_x  = series_x_q;
    assign series_y  = series_y_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_pair  = res_pair_q;
    assign res_lag   = res_lag_q;

endmodule

// File: tb/tb_xcorr_pair_feeder.sv
// Bench for xcorr_pair_feeder: random frames, random correlator strobes,
// checked cycle by cycle against a phase-level model of the sweep.
module tb_xcorr_pair_feeder;

    localparam int W       = 16;
    localparam int DEPTH   = 8;
    localparam int NCH     = 4;
    localparam int PAD     = 8;
    localparam int NLAG    = 15;
    localparam int RW      = 32;
    localparam int ARM_CYC = 2;
    localparam int PW      = 2;
    localparam int LW      = 4;
    localparam int NP      = NCH - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             abort;
    logic             pair_mode;
    logic             in_valid;
    logic [NCH*W-1:0] in_data;
    logic             in_ready;
    logic [W-1:0]     series_x;
    logic [W-1:0]     series_y;
    logic             xc_start;
    logic             xc_complete;
    logic [RW-1:0]    xc_result;
    logic             res_valid;
    logic [RW-1:0]    res_data;
    logic [PW-1:0]    res_pair;
    logic [LW-1:0]    res_lag;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] frame [DEPTH][NCH];
    bit           hold_v;
    bit           res_plan;
    int           cpl_pct;
    int           lag_m;
    int           pair_m;
    bit           pend_v;
    logic [RW-1:0] pend_d;
    int           pend_p;
    int           pend_l;

    xcorr_pair_feeder #(
        .W(W), .DEPTH(DEPTH), .NCH(NCH), .PAD(PAD),
        .NLAG(NLAG), .RW(RW), .ARM_CYC(ARM_CYC)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort), .pair_mode(pair_mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .series_x(series_x), .series_y(series_y), .xc_start(xc_start),
        .xc_complete(xc_complete), .xc_result(xc_result),
        .res_valid(res_valid), .res_data(res_data), .res_pair(res_pair),
        .res_lag(res_lag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk_eq({tag, "_in_ready"},  in_ready,  0);
        chk_eq({tag, "_series_x"},  series_x,  0);
        chk_eq({tag, "_series_y"},  series_y,  0);
        chk_eq({tag, "_xc_start"},  xc_start,  1);
        chk_eq({tag, "_res_valid"}, res_valid, 0);
        chk_eq({tag, "_res_data"},  res_data,  0);
        chk_eq({tag, "_res_pair"},  res_pair,  0);
        chk_eq({tag, "_res_lag"},   res_lag,   0);
        chk_eq({tag, "_busy"},      busy,      0);
        chk_eq({tag, "_done"},      done,      0);
    endtask

    // One clock: check this cycle's outputs, then drive inputs for the next edge.
    // act = pair is streaming/draining, so a strobe now yields a result next cycle.
    task automatic cyc(input bit e_rdy, input bit e_st, input logic [W-1:0] e_x,
                       input logic [W-1:0] e_y, input bit e_busy, input bit e_done,
                       input bit act, input bit ab, input bit r);
        @(negedge clk);
        chk_eq("in_ready",  in_ready,  e_rdy);
        chk_eq("xc_start",  xc_start,  e_st);
        chk_eq("series_x",  series_x,  e_x);
        chk_eq("series_y",  series_y,  e_y);
        chk_eq("busy",      busy,      e_busy);
        chk_eq("done",      done,      e_done);
        chk_eq("res_valid", res_valid, pend_v);
        if (pend_v && res_valid) begin
            chk_eq("res_data", res_data, pend_d);
            chk_eq("res_pair", res_pair, pend_p);
            chk_eq("res_lag",  res_lag,  pend_l);
        end
        pend_v      = 1'b0;
        abort       = ab;
        run         = e_busy ? ($urandom_range(0, 7) == 0) : r;
        pair_mode   = $urandom_range(0, 1);
        in_valid    = hold_v ? 1'b1 : 1'($urandom_range(0, 1));
        in_data     = {$urandom, $urandom};
        xc_complete = ($urandom_range(0, 99) < cpl_pct);
        xc_result   = res_plan ? RW'(lag_m * 3) : $urandom;
        if (xc_complete && act && !ab && lag_m < NLAG) begin
            pend_v = 1'b1;
            pend_d = xc_result;
            pend_p = pair_m;
            pend_l = lag_m;
            lag_m++;
        end
    endtask

    task automatic idle_cyc(input bit r);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, r);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1 check_reset("arst");
        xc_complete = 1'b0;
        run         = 1'b0;
        abort       = 1'b0;
        @(negedge clk);
        check_reset("arst_hold");
        rst    = 1'b0;
        pend_v = 1'b0;
        idle_cyc(0);
    endtask

    // One full fill + sweep as the model sees it, with optional abort at
    // (ab_pair, ab_k) of STREAM or async reset in the first DRAIN cycle of rst_pair.
    task automatic do_run(input bit mode, input bit plan_data, input int ab_pair,
                          input int ab_k, input int rst_pair);
        int n;
        int guard;
        int xc;
        int yc;
        bit last;
        bit ab;
        idle_cyc(0);
        idle_cyc(0);
        idle_cyc(1);
        pair_mode = mode;
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < NCH; c++) begin
                frame[i][c] = plan_data ? W'(c * 100 + i) : W'($urandom);
            end
        end
        n = 0;
        guard = 0;
        while (n < DEPTH) begin
            cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
            in_valid = hold_v || (guard > 20) || ($urandom_range(0, 1) == 1);
            if (in_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    in_data[c*W +: W] = frame[n][c];
                end
                n++;
            end
            guard++;
        end
        for (int p = 0; p < NP; p++) begin
            pair_m = p;
            lag_m  = 0;
            xc = mode ? p : 0;
            yc = p + 1;
            repeat (ARM_CYC) cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
            for (int k = 0; k <= DEPTH + PAD; k++) begin
                ab = (p == ab_pair) && (k == ab_k);
                if (k >= 1 && k <= DEPTH) begin
                    cyc(0, 0, frame[k-1][xc], frame[k-1][yc], 1, 0, 1, ab, 0);
                end else begin
                    cyc(0, 0, 0, 0, 1, 0, 1, ab, 0);
                end
                if (ab) begin
                    idle_cyc(0);
                    return;
                end
            end
            guard = 0;
            do begin
                last = (lag_m == NLAG);
                cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
                if (p == rst_pair) begin
                    reset_mid();
                    return;
                end
                guard++;
            end while (!last && guard < 400);
            chk_eq("drain_bound", last, 1);
        end
        cyc(0, 1, 0, 0, 1, 1, 0, 0, 0);
        idle_cyc(0);
    endtask

    initial begin
        rst         = 1'b1;
        run         = 1'b0;
        abort       = 1'b0;
        pair_mode   = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        xc_complete = 1'b0;
        xc_result   = '0;
        hold_v      = 1'b0;
        res_plan    = 1'b0;
        cpl_pct     = 50;
        pend_v      = 1'b0;
        lag_m       = 0;
        pair_m      = 0;
        #3 check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // plan data, mode 0, strobe every cycle: lags 0..14, extra strobes dropped
        hold_v = 1'b1; res_plan = 1'b1; cpl_pct = 100;
        do_run(0, 1, -1, 0, -1);
        // plan data, mode 1, random handshake and strobes
        hold_v = 1'b0; res_plan = 1'b0; cpl_pct = 50;
        do_run(1, 1, -1, 0, -1);
        // abort in the middle of pair 1, then a clean restart
        cpl_pct = 60;
        do_run(0, 0, 1, 5, -1);
        do_run(0, 0, -1, 0, -1);
        // async reset during the first DRAIN, then a full run afterwards
        do_run(1, 0, -1, 0, 0);
        cpl_pct = 40;
        do_run(1, 0, -1, 0, -1);
        repeat (2) idle_cyc(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
